// File: rtl/data_mem_resp.sv
// Word-organised data memory with a single outstanding request, a programmable
// wait-state delay and a valid/ready response channel.
module data_mem_resp #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state;
    logic [3:0]    wait_cnt;

    logic          lat_write;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic [3:0]    lat_be;

    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          commit;
    logic          addr_err;
    logic [AW-1:0] word_idx;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    // State is forced to IDLE asynchronously, so ready must also be gated by reset.
    assign req_ready = (state == S_IDLE) && reset;
    assign accept    = req_valid && req_ready;
    assign commit    = (state == S_WAIT) && (wait_cnt == 4'd0);
    assign addr_err  = (lat_addr[1:0] != 2'b00) || (lat_addr[31:2] >= 30'(DEPTH));
    assign word_idx  = lat_addr[AW+1:2];

    // Request capture: plain data registers, only meaningful while an access is in flight.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
        end
    end

    // Storage keeps its contents across reset; a write happens only on a clean store commit.
    always_ff @(posedge clk) begin
        if (commit && lat_write && !addr_err) begin
            mem[word_idx] <= merge_bytes(mem[word_idx], lat_wdata, lat_be);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state    <= S_WAIT;
                        wait_cnt <= 4'(WAIT_CYCLES);
                    end
                end
                S_WAIT: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= addr_err;
                        rsp_rdata <= (lat_write || addr_err) ? 32'd0 : mem[word_idx];
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter DEPTH, default 64, SHALL give the storage depth in 32-bit words (1..1024).
REQ-002 Parameter WAIT_CYCLES, default 2, SHALL give the number of added wait states per access (0..15).
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 req_valid  input  1  SHALL indicate the initiator presents a request.
REQ-006 req_ready  output  1  SHALL indicate the block can accept a request.
REQ-007 req_write  input  1  SHALL select store (1) or load (0).
REQ-008 req_addr  input  32  SHALL carry the byte address.
REQ-009 req_wdata  input  32  SHALL carry the store data.
REQ-010 req_be  input  4  SHALL carry the store byte enables; bit i covers byte lane i.
REQ-011 rsp_valid  output  1  SHALL indicate the response is valid.
REQ-012 rsp_ready  input  1  SHALL indicate the initiator accepts the response.
REQ-013 rsp_rdata  output  32  SHALL carry the load data.
REQ-014 rsp_err  output  1  SHALL flag a rejected access.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE with reset deasserted, and 0 in WAIT and RESP.
REQ-017 Acceptance SHALL occur at a rising edge where req_valid=1 and req_ready=1.
REQ-018 At acceptance the block SHALL latch req_write, req_addr, req_wdata and req_be, load wait counter = WAIT_CYCLES, and go to WAIT.
REQ-019 In WAIT with counter != 0, each edge SHALL decrement the counter.
REQ-020 In WAIT with counter == 0, the next edge SHALL commit the access and enter RESP.
REQ-021 rsp_valid SHALL first be 1 exactly WAIT_CYCLES+1 edges after the acceptance edge.
REQ-022 Commit on a store SHALL write each byte lane whose req_be bit is 1, leave the other lanes unchanged, and set rsp_rdata = 0.
REQ-023 Commit on a load SHALL set rsp_rdata to the full addressed word; req_be SHALL be ignored on loads.
REQ-024 An access SHALL be an error if req_addr[1:0] != 0 or req_addr[31:2] >= DEPTH.
REQ-025 On an error commit, storage SHALL be unchanged, rsp_rdata = 0 and rsp_err = 1; otherwise rsp_err = 0.
REQ-026 A store with req_be = 0000 SHALL change no storage and report rsp_err = 0.
REQ-027 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL remain stable until an edge where rsp_ready = 1.
REQ-028 At that edge the block SHALL return to IDLE, with rsp_valid = 0 from the next cycle.
REQ-029 No new request SHALL be accepted at the response-handshake edge; the minimum request-to-request spacing is WAIT_CYCLES+3 edges.
REQ-030 rsp_ready asserted outside RESP SHALL have no effect.
REQ-031 req_* inputs SHALL be ignored outside IDLE.
REQ-032 Storage SHALL be an internal register array and SHALL NOT be initialised by reset.

Reset
REQ-033 While reset = 0, the block SHALL be in IDLE with rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, counter = 0 and req_ready = 0, taking effect immediately without waiting for clk.
REQ-034 Reset asserted in WAIT SHALL abort the access with no storage write.
REQ-035 Reset asserted in RESP SHALL drop the pending response.
REQ-036 Storage contents written before reset SHALL be preserved across reset.
REQ-037 After reset deasserts, req_ready SHALL be 1 in the next cycle.

Verification
REQ-038 Store-then-load: WAIT_CYCLES=2; store addr 0x10, data 0xDEADBEEF, be 1111; then load addr 0x10 -> rsp_rdata 0xDEADBEEF, rsp_err 0, each rsp_valid 3 edges after acceptance.
REQ-039 Byte enables: store 0x11223344 at addr 0x20 with be 1111, then store 0xAABBCCDD at addr 0x20 with be 0101, then load addr 0x20 -> 0x11BB33DD.
REQ-040 Errors: load addr 0x22 -> rsp_err 1, rdata 0; store addr 4*DEPTH -> rsp_err 1; a later load of word DEPTH-1 is unchanged.
REQ-041 Backpressure: hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and req_ready = 0 held stable; with req_valid held high, the next acceptance occurs only after the handshake edge.
REQ-042 Reset mid-operation: assert reset in WAIT of a store to 0x30 -> outputs clear immediately, the word at 0x30 keeps its old value, and req_ready = 1 the cycle after release.
REQ-043 WAIT_CYCLES = 0 build: rsp_valid is 1 one edge after acceptance, and back-to-back requests are spaced 3 edges apart.
